// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, default operand width and the divide-by-zero quotient pattern.
package mult_div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [WIDTH_DEF-1:0] DIVZ_LO = '1;

  // Odd encodings are the unsigned variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HIcur;
  logic [WIDTH-1:0] LOcur;
  logic [WIDTH-1:0] HIout;
  logic [WIDTH-1:0] LOout;
  logic             HIen;
  logic             LOen;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Op, A, B, HIcur, LOcur,
    input  HIout, LOout, HIen, LOen, Busy, Done
  );

  modport slave (
    input  Start, Op, A, B, HIcur, LOcur,
    output HIout, LOout, HIen, LOen, Busy, Done
  );
endinterface

// File: rtl/mult_div_unit_iter_step.sv
// One combinational iteration on the {hi,lo} working pair: shift-add for
// multiply, restoring compare-subtract for divide.
module mdu_iter_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum    = {1'b0, hi} + {1'b0, opnd};
    rem_sh = {hi, lo[WIDTH-1]};
    // One extra bit above rem_sh so diff[WIDTH+1] is a true borrow flag.
    diff   = {1'b0, rem_sh} - {2'b00, opnd};
    hi_nxt = hi;
    lo_nxt = lo;
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      {hi_nxt, lo_nxt} = {sum, lo[WIDTH-1:1]};
    end else begin
      {hi_nxt, lo_nxt} = {1'b0, hi, lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one op at a time, WIDTH iterations,
// then a single write cycle pulsing the HI/LO enables.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic            Clk,
  input  logic            Rst,
  mult_div_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             busy, done, hi_en, lo_en;
  logic [WIDTH-1:0] hi_out, lo_out;

  op_e              op_q;
  logic             signed_q, is_div_q, div0_q, sa_q, sb_q;
  logic [WIDTH-1:0] a_q, opnd_q, hi_q, lo_q, hicur_q, locur_q;

  logic [WIDTH-1:0]   hi_nx, lo_nx, hi_fix, lo_fix, quo, rem;
  logic [2*WIDTH-1:0] prod, mres;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic sgn);
    return (sgn && v < 0) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v,
                                             input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v,
                                                input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .hi_nxt (hi_nx),
    .lo_nxt (lo_nx)
  );

  // Sign fixup and accumulate act on the final iteration's output so the
  // write cycle follows the last iteration directly.
  always_comb begin
    prod = neg_2w({hi_nx, lo_nx}, signed_q && (sa_q ^ sb_q));
    case (op_q)
      OP_MADD, OP_MADDU: mres = {hicur_q, locur_q} + prod;
      OP_MSUB, OP_MSUBU: mres = {hicur_q, locur_q} - prod;
      default:           mres = prod;
    endcase
    quo = neg_w(lo_nx, signed_q && (sa_q ^ sb_q));
    rem = neg_w(hi_nx, signed_q && sa_q);
    if (!is_div_q) begin
      {hi_fix, lo_fix} = mres;
    end else if (div0_q) begin
      hi_fix = a_q;
      lo_fix = WIDTH'(DIVZ_LO);
    end else begin
      hi_fix = rem;
      lo_fix = quo;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_en  <= 1'b0;
      lo_en  <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            state <= ST_RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= ST_WRITE;
            done   <= 1'b1;
            hi_en  <= 1'b1;
            lo_en  <= 1'b1;
            hi_out <= hi_fix;
            lo_out <= lo_fix;
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          hi_en <= 1'b0;
          lo_en <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand/working registers: loaded on accept, stepped while running.
  always_ff @(posedge Clk) begin
    if (state == ST_IDLE && bus.Start) begin
      op_q     <= op_e'(bus.Op);
      signed_q <= op_is_signed(bus.Op);
      is_div_q <= op_is_div(bus.Op);
      div0_q   <= (bus.B == '0);
      sa_q     <= bus.A[WIDTH-1];
      sb_q     <= bus.B[WIDTH-1];
      a_q      <= bus.A;
      hicur_q  <= bus.HIcur;
      locur_q  <= bus.LOcur;
      hi_q     <= '0;
      lo_q     <= mag(bus.A, op_is_signed(bus.Op));
      opnd_q   <= mag(bus.B, op_is_signed(bus.Op));
    end else if (state == ST_RUN) begin
      hi_q <= hi_nx;
      lo_q <= lo_nx;
    end
  end

  assign bus.Busy  = busy;
  assign bus.Done  = done;
  assign bus.HIen  = hi_en;
  assign bus.LOen  = lo_en;
  assign bus.HIout = hi_out;
  assign bus.LOout = lo_out;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, write-cycle
// timing, ignored restarts and mid-op reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   failures = 0;

  mult_div_unit_if #(.WIDTH(32)) mdu_bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (mdu_bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Presents an op for one edge, then scrambles the inputs; returns in cycle t+1.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hc, input logic [31:0] lc);
    mdu_bus.Start = 1'b1;
    mdu_bus.Op    = op;
    mdu_bus.A     = a;
    mdu_bus.B     = b;
    mdu_bus.HIcur = hc;
    mdu_bus.LOcur = lc;
    tick();
    mdu_bus.Start = 1'b0;
    mdu_bus.Op    = ~op;
    mdu_bus.A     = 32'hDEADBEEF;
    mdu_bus.B     = 32'h12345678;
    mdu_bus.HIcur = 32'h0BADF00D;
    mdu_bus.LOcur = 32'hCAFEBABE;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hc, input logic [31:0] lc,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    int busy_bad = 0;
    int early    = 0;
    launch(op, a, b, hc, lc);
    for (int k = 1; k <= 32; k++) begin
      if (mdu_bus.Busy !== 1'b1) busy_bad++;
      if (mdu_bus.Done !== 1'b0 || mdu_bus.HIen !== 1'b0 || mdu_bus.LOen !== 1'b0) early++;
      tick();
    end
    chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    chk({tag, "_early_strobe"}, 64'(early), 64'd0);
    chk({tag, "_write_strobes"},
        64'({mdu_bus.Busy, mdu_bus.Done, mdu_bus.HIen, mdu_bus.LOen}), 64'hF);
    chk({tag, "_hilo"}, {mdu_bus.HIout, mdu_bus.LOout}, {eh, el});
    tick();
    chk({tag, "_after_strobes"},
        64'({mdu_bus.Busy, mdu_bus.Done, mdu_bus.HIen, mdu_bus.LOen}), 64'h0);
    chk({tag, "_hold"}, {mdu_bus.HIout, mdu_bus.LOout}, {eh, el});
  endtask

  initial begin
    int dcount;
    int dcyc;
    int encount;
    logic [63:0] res;

    Rst = 1'b1;
    mdu_bus.Start = 1'b0;
    mdu_bus.Op    = 3'b000;
    mdu_bus.A     = '0;
    mdu_bus.B     = '0;
    mdu_bus.HIcur = '0;
    mdu_bus.LOcur = '0;
    tick();
    tick();
    chk("reset_ctrl", 64'({mdu_bus.Busy, mdu_bus.Done, mdu_bus.HIen, mdu_bus.LOen}), 64'h0);
    chk("reset_hilo", {mdu_bus.HIout, mdu_bus.LOout}, 64'h0);
    Rst = 1'b0;
    tick();

    run_op(OP_MULT,  32'hFFFFFFFD, 32'd7, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
    run_op(OP_DIVU,  32'd100, 32'd7, 0, 0, 32'd2, 32'd14, "divu");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_negdvd");
    run_op(OP_DIV,   32'd7, 32'hFFFFFFFE, 0, 0, 32'd1, 32'hFFFFFFFD, "div_negdvs");
    run_op(OP_DIV,   32'd5, 32'd0, 0, 0, 32'd5, 32'hFFFFFFFF, "div_by0");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd0, 0, 0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0");
    run_op(OP_DIVU,  32'hFFFFFFFF, 32'd0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, "divu_by0");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 32'd0, 32'h80000000, "div_ovf");
    run_op(OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, "maddu_carry");
    run_op(OP_MSUB,  32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "msub_wrap");
    run_op(OP_MADD,  32'hFFFFFFFE, 32'd3, 32'd0, 32'd10, 32'd0, 32'd4, "madd_neg");
    run_op(OP_MSUBU, 32'd2, 32'd3, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFA, "msubu");
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    run_op(OP_MULT,  32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h0, "mult_minmin");
    run_op(OP_MULT,  32'h80000000, 32'd1, 0, 0, 32'hFFFFFFFF, 32'h80000000, "mult_min1");

    // Second Start while busy must be dropped.
    dcount = 0;
    dcyc   = 0;
    res    = '0;
    launch(OP_MULTU, 32'd6, 32'd7, 0, 0);
    for (int c = 1; c <= 70; c++) begin
      if (mdu_bus.Done === 1'b1) begin
        dcount++;
        dcyc = c;
        res  = {mdu_bus.HIout, mdu_bus.LOout};
      end
      if (c == 5) begin
        mdu_bus.Start = 1'b1;
        mdu_bus.Op    = OP_MULTU;
        mdu_bus.A     = 32'd9;
        mdu_bus.B     = 32'd9;
      end
      if (c == 6) mdu_bus.Start = 1'b0;
      tick();
    end
    chk("busy_start_done_count", 64'(dcount), 64'd1);
    chk("busy_start_done_cycle", 64'(dcyc), 64'd33);
    chk("busy_start_result", res, 64'd42);

    // Reset mid-op, then a fresh op two cycles later.
    dcount  = 0;
    dcyc    = 0;
    encount = 0;
    res     = '0;
    launch(OP_MULTU, 32'd6, 32'd7, 0, 0);
    for (int c = 1; c <= 50; c++) begin
      if (c <= 44 && (mdu_bus.HIen === 1'b1 || mdu_bus.LOen === 1'b1)) encount++;
      if (mdu_bus.Done === 1'b1) begin
        dcount++;
        dcyc = c;
        res  = {mdu_bus.HIout, mdu_bus.LOout};
      end
      if (c == 11) begin
        chk("midrst_ctrl", 64'({mdu_bus.Busy, mdu_bus.Done, mdu_bus.HIen, mdu_bus.LOen}), 64'h0);
        chk("midrst_hilo", {mdu_bus.HIout, mdu_bus.LOout}, 64'h0);
      end
      if (c == 10) Rst = 1'b1;
      if (c == 11) Rst = 1'b0;
      if (c == 12) begin
        mdu_bus.Start = 1'b1;
        mdu_bus.Op    = OP_DIVU;
        mdu_bus.A     = 32'd100;
        mdu_bus.B     = 32'd7;
      end
      if (c == 13) mdu_bus.Start = 1'b0;
      tick();
    end
    chk("midrst_no_enable", 64'(encount), 64'd0);
    chk("midrst_done_count", 64'(dcount), 64'd1);
    chk("midrst_done_cycle", 64'(dcyc), 64'd45);
    chk("midrst_result", res, {32'd2, 32'd14});

    // Reset and Start together: the op must not be accepted.
    Rst = 1'b1;
    mdu_bus.Start = 1'b1;
    mdu_bus.Op    = OP_MULTU;
    mdu_bus.A     = 32'd3;
    mdu_bus.B     = 32'd3;
    tick();
    Rst = 1'b0;
    mdu_bus.Start = 1'b0;
    dcount = 0;
    encount = 0;
    for (int c = 1; c <= 40; c++) begin
      if (mdu_bus.Busy !== 1'b0) encount++;
      if (mdu_bus.Done !== 1'b0) dcount++;
      tick();
    end
    chk("rst_start_busy", 64'(encount), 64'd0);
    chk("rst_start_done", 64'(dcount), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
